// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Fetch stage feeding decode. Owns the PC and issues in-order
//             requests to instruction memory. Buffers returned words in a
//             DEPTH-entry FIFO and drives the F/D register (pcD, instrD,
//             validD). Redirects to pcnD on a decode control change and
//             discards wrong-path requests and responses.
//  Ports    : clk, reset (sync, active-low)
//             en              - F/D enable from hazard unit (0 = stall)
//             controllchangeD - decode redirect request, pcnD = target
//             imem_req/imem_addr/imem_ready      - request channel
//             imem_rvalid/imem_rdata             - in-order response channel
//             pcD/instrD/validD                  - F/D register outputs
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int               WORD     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WORD-1:0]  RESET_PC = '0,
    parameter logic [WORD-1:0]  NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            controllchangeD,
    input  logic [WORD-1:0] pcnD,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [WORD-1:0] imem_rdata,
    output logic [WORD-1:0] pcD,
    output logic [WORD-1:0] instrD,
    output logic            validD
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Architectural state
    logic [WORD-1:0]  pc_q,      pc_d;
    logic [CNT_W-1:0] out_q,     out_d;     // requests accepted, no response yet
    logic [CNT_W-1:0] drop_q,    drop_d;    // in-flight responses known stale
    logic [CNT_W-1:0] cnt_q,     cnt_d;     // instruction FIFO occupancy
    logic [PTR_W-1:0] rd_q,      rd_d;
    logic [PTR_W-1:0] wr_q,      wr_d;
    logic [PTR_W-1:0] rq_rd_q,   rq_rd_d;   // request-PC FIFO pointers
    logic [PTR_W-1:0] rq_wr_q,   rq_wr_d;
    logic [WORD-1:0]  pcD_q,     pcD_d;
    logic [WORD-1:0]  instrD_q,  instrD_d;
    logic             validD_q,  validD_d;

    // Storage (no reset needed; validity is tracked by the pointers/counts)
    logic [WORD-1:0]  fifo_pc_q    [DEPTH];
    logic [WORD-1:0]  fifo_instr_q [DEPTH];
    logic [WORD-1:0]  rq_pc_q      [DEPTH];

    logic             redir;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;

    // A redirect only counts when decode holds a real instruction and is
    // not stalled; a stalled decode re-raises it later.
    assign redir     = en & validD_q & controllchangeD;
    // Credit: every outstanding request has a guaranteed FIFO slot, so the
    // sum of in-flight and buffered words never exceeds DEPTH.
    assign occupancy = {1'b0, out_q} + {1'b0, cnt_q};
    assign imem_req  = reset & (occupancy < (CNT_W+1)'(DEPTH)) & ~redir;
    assign imem_addr = pc_q;
    assign accept    = imem_req & imem_ready;
    // A same-cycle push is discarded by a redirect (FIFO flush wins).
    assign push      = imem_rvalid & (drop_q == '0) & ~redir;
    assign pop       = en & ~redir & (cnt_q != '0);

    assign pcD    = pcD_q;
    assign instrD = instrD_q;
    assign validD = validD_q;

    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rq_rd_d  = rq_rd_q;
        rq_wr_d  = rq_wr_q;
        pcD_d    = pcD_q;
        instrD_d = instrD_q;
        validD_d = validD_q;

        if (redir) begin
            pc_d = pcnD;
        end else if (accept) begin
            pc_d = pc_q + WORD'(4);
        end

        // Request-PC FIFO tracks every in-flight request, stale or not,
        // so it advances on every response regardless of drop.
        if (accept) begin
            rq_wr_d = rq_wr_q + PTR_W'(1);
        end
        if (imem_rvalid) begin
            rq_rd_d = rq_rd_q + PTR_W'(1);
        end

        if (redir) begin
            // Everything still in flight after this edge is wrong-path.
            drop_d = drop_q + out_q - CNT_W'(imem_rvalid);
        end else if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end

        if (redir) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end

        if (en) begin
            if (redir) begin
                validD_d = 1'b0;
                instrD_d = NOP;
                pcD_d    = '0;
            end else if (pop) begin
                validD_d = 1'b1;
                instrD_d = fifo_instr_q[rd_q];
                pcD_d    = fifo_pc_q[rd_q];
            end else begin
                validD_d = 1'b0;
                instrD_d = NOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            rq_rd_q  <= '0;
            rq_wr_q  <= '0;
            pcD_q    <= '0;
            instrD_q <= NOP;
            validD_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rq_rd_q  <= rq_rd_d;
            rq_wr_q  <= rq_wr_d;
            pcD_q    <= pcD_d;
            instrD_q <= instrD_d;
            validD_q <= validD_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rq_pc_q[rq_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_pc_q[wr_q]    <= rq_pc_q[rq_rd_q];
            fifo_instr_q[wr_q] <= imem_rdata;
        end
    end

`ifndef SYNTHESIS
    // Memory must never respond without an outstanding request.
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (out_q != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. A driver models an
//             in-order instruction memory and the decode/hazard inputs and
//             queues the expected program-order PCs; a monitor checks every
//             F/D register update against that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          WORD     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        controllchangeD;
    logic [31:0] pcnD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        validD;

    always #5 clk = ~clk;

    fetch_queue #(
        .WORD     (WORD),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP      (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .controllchangeD (controllchangeD),
        .pcnD            (pcnD),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .pcD             (pcD),
        .instrD          (instrD),
        .validD          (validD)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] exp_q[$];        // program-order PCs decode should see next
    logic [31:0] exp_next;        // next PC to append to exp_q
    logic [31:0] exp_fetch_pc;    // next address the fetch unit should request
    logic [31:0] pend[$];         // memory model: accepted, unanswered requests
    logic        prev_stall;
    logic        prev_was_reset;
    logic [31:0] prev_addr;
    bit          lat_arm;
    bit          tput_arm;
    int          nvalid = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, check request side 1ns later.
    task automatic step(input logic rst_n, input logic en_i, input int ready_pct,
                        input int rv_pct, input logic cc_i, input logic [31:0] tgt);
        logic [31:0] a;
        logic        redir_now;
        @(negedge clk);
        reset           = rst_n;
        en              = en_i;
        controllchangeD = cc_i;
        pcnD            = tgt;
        imem_ready      = (int'($urandom_range(99)) < ready_pct);
        if (rst_n && pend.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
            a           = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        redir_now = rst_n & en_i & validD & cc_i;
        if (!rst_n) begin
            chk("req_in_reset", 32'(imem_req), 32'd0);
            pend.delete();
            exp_q.delete();
            exp_next     = RESET_PC;
            exp_fetch_pc = RESET_PC;
        end else begin
            if (prev_was_reset)
                chk("addr_after_reset", imem_addr, RESET_PC);
            if (redir_now)
                chk("req_in_redirect", 32'(imem_req), 32'd0);
            if (prev_stall) begin
                chk("stall_addr_stable", imem_addr, prev_addr);
                chk("stall_req_held", 32'(imem_req), 32'(!redir_now));
            end
            if (imem_req)
                chk("fetch_addr", imem_addr, exp_fetch_pc);
            if (imem_req && imem_ready) begin
                pend.push_back(imem_addr);
                exp_fetch_pc = exp_fetch_pc + 32'd4;
                chk("credit_le_depth", 32'(pend.size() <= DEPTH), 32'd1);
            end
            if (redir_now) begin
                exp_q.delete();
                exp_next     = tgt;
                exp_fetch_pc = tgt;
            end
        end
        prev_stall     = rst_n && imem_req && !imem_ready;
        prev_addr      = imem_addr;
        prev_was_reset = !rst_n;
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    // Monitor: evaluates each F/D register update just after the edge.
    initial begin : monitor
        logic        m_pv   = 1'b0;
        logic [31:0] m_ppc  = '0;
        logic [31:0] m_pins = '0;
        logic [31:0] e;
        int          edges  = 0;
        bit          seen_first = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                chk("rst_validD", 32'(validD), 32'd0);
                chk("rst_pcD", pcD, 32'd0);
                chk("rst_instrD", instrD, NOP);
                edges      = 0;
                seen_first = 0;
            end else begin
                edges++;
                if (!en) begin
                    chk("stall_hold_validD", 32'(validD), 32'(m_pv));
                    chk("stall_hold_pcD", pcD, m_ppc);
                    chk("stall_hold_instrD", instrD, m_pins);
                end else if (m_pv && controllchangeD) begin
                    chk("redir_validD", 32'(validD), 32'd0);
                    chk("redir_pcD", pcD, 32'd0);
                    chk("redir_instrD", instrD, NOP);
                end else if (validD) begin
                    if (!seen_first && lat_arm)
                        chk("first_latency", 32'(edges), 32'd3);
                    seen_first = 1;
                    nvalid++;
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pcD", pcD, e);
                        chk("instrD", instrD, memfn(e));
                    end
                end else begin
                    chk("bubble_instrD", instrD, NOP);
                    if (tput_arm && seen_first)
                        chk("throughput", 32'(validD), 32'd1);
                end
            end
            m_pv   = validD;
            m_ppc  = pcD;
            m_pins = instrD;
        end
    end

    initial begin : driver
        int          k;
        logic [31:0] t;
        reset           = 1'b0;
        en              = 1'b0;
        controllchangeD = 1'b0;
        pcnD            = '0;
        imem_ready      = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = '0;
        exp_next        = RESET_PC;
        exp_fetch_pc    = RESET_PC;
        prev_stall      = 1'b0;
        prev_was_reset  = 1'b1;
        prev_addr       = '0;
        lat_arm         = 1;
        tput_arm        = 0;

        // Reset, then zero-wait streaming until decode holds 0x10.
        repeat (3) step(1'b0, 1'b1, 100, 100, 1'b0, 32'h0);
        tput_arm = 1;
        k = 0;
        while (!(validD && pcD == 32'h10) && k < 50) begin
            step(1'b1, 1'b1, 100, 100, 1'b0, 32'h0);
            k++;
        end
        chk("reach_pc_0x10", 32'(validD && pcD == 32'h10), 32'd1);
        tput_arm = 0;

        // Branch to 0x100 with requests in flight.
        step(1'b1, 1'b1, 100, 100, 1'b1, 32'h100);

        // Decode stall mid-stream.
        repeat (10) step(1'b1, 1'b1, 100, 100, 1'b0, 32'h0);
        repeat (5)  step(1'b1, 1'b0, 100, 100, 1'b0, 32'h0);
        repeat (10) step(1'b1, 1'b1, 100, 100, 1'b0, 32'h0);

        // Memory not ready for 10 cycles.
        repeat (10) step(1'b1, 1'b1, 0, 100, 1'b0, 32'h0);
        repeat (6)  step(1'b1, 1'b1, 100, 100, 1'b0, 32'h0);

        // Fill the FIFO under stall, then reset mid-stream.
        repeat (8) step(1'b1, 1'b0, 100, 100, 1'b0, 32'h0);
        chk("full_before_reset", 32'(pend.size() == 0 && !imem_req), 32'd1);
        lat_arm = 1;
        step(1'b0, 1'b1, 100, 100, 1'b0, 32'h0);
        repeat (15) step(1'b1, 1'b1, 100, 100, 1'b0, 32'h0);
        lat_arm = 0;

        // Randomised traffic: stalls, backpressure, variable latency,
        // redirects (also while stalled or in bubbles), rare resets.
        repeat (3000) begin
            t = 32'($urandom_range(1023)) << 2;
            step(($urandom_range(499) != 0), (int'($urandom_range(99)) < 80),
                 75, 70, (int'($urandom_range(99)) < 10), t);
        end
        step(1'b1, 1'b1, 100, 100, 1'b0, 32'h0);
        chk("progress", 32'(nvalid > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
